load_share_arbiter: RTL and testbench
=====================================

Name: load_share_arbiter

Overview:
- Shares one conditional-load unit between N requesters.
- The load unit writes dout[g] <= data[g] only when the granted requester's enable is high.
- Round-robin arbitration; one service per 3-cycle transaction.
- Replaces per-requester parallel calls of the conditional-copy task with a single sequenced resource in the counter/flag datapath.

Parameters:
- N, 2, number of requesters (2..8)
- W, 4, data width per requester
- IDXW, $clog2(N) (min 1), grant index width (derived, not overridden)

Ports:
- clk  in  1  system clock, rising edge
- rstn  in  1  asynchronous active-low reset
- req_i  in  N  per-requester request level; hold until done_o[i]
- en_i  in  N  per-requester load enable; sampled in SERVE only
- data_i  in  N*W  packed load values; requester i at [i*W +: W]
- gnt_o  out  N  one-hot grant, high during SERVE
- done_o  out  N  one-hot completion pulse, high during ACK
- dout_o  out  N*W  packed per-requester result registers
- busy_o  out  1  high whenever state != IDLE

Behaviour:
- Reset (rstn low, async): state=IDLE, rr_ptr=0, gnt_o=0, done_o=0, busy_o=0, all dout_o fields=0.
- FSM states:
  - IDLE: if any req_i (after masking), register winner g and go to SERVE; else stay.
  - SERVE: gnt_o[g]=1 for exactly one cycle. At the closing edge: if en_i[g]=1 then dout[g] <= data_i[g], else dout[g] holds. Go to ACK.
  - ACK: done_o[g]=1 for exactly one cycle. At the closing edge: rr_ptr <= (g+1) mod N, go to IDLE.
- Winner selection: first set bit of req_i scanning from rr_ptr upward with wrap, i.e. rr_ptr, rr_ptr+1, ..., N-1, 0, ..., rr_ptr-1.
- Latency: req_i sampled high at edge k in IDLE -> gnt_o high in cycle k+1 -> dout updated and done_o high in cycle k+2 -> IDLE in cycle k+3.
- Peak throughput: one load per 3 cycles.
- Requester obligations:
  - Drop req_i in the cycle done_o[i] is high.
  - Keep data_i/en_i stable during gnt_o[i].
- Masking: in IDLE, any req_i bit whose done_o was high in the previous cycle is ignored for that one cycle. This prevents a late-dropping requester from being re-granted.
- Simultaneous requests: resolved purely by rr_ptr; no fixed priority.
- req_i[g] dropping during SERVE: transaction still completes (load + done). The grant is committed at IDLE->SERVE.
- en_i[g]=0 in SERVE: dout[g] unchanged, done_o[g] still pulses.
- dout fields of non-granted requesters never change.
- rr_ptr wrap: g=N-1 -> rr_ptr=0.
- Reset mid-SERVE/ACK: immediate return to reset values; the pending load is discarded; done is not issued.
- Outputs gnt_o, done_o and busy_o are registered (decoded from state and g flops); no combinational path from inputs to outputs.

Optional Feature:
- Macro: LOAD_SHARE_ARBITER_STATS_EN.
- Defined:
  - Adds output port grant_cnt_o (N*8 bits), one 8-bit counter per requester.
  - A counter increments at each ACK closing edge for its g, whether or not the load was enabled.
  - Counters wrap 255->0 and reset to 0 on rstn.
- Undefined: port and counters are absent; all other behaviour is identical.

Decomposition:
- Package load_share_pkg:
  - state enum typedef (IDLE=2'd0, SERVE=2'd1, ACK=2'd2)
  - STATS_W=8 constant
- Sub-module rr_pick (combinational): inputs req masked vector and rr_ptr; outputs valid and winner index. Instantiated once.
- FSM, load datapath and dout registers live in the top module.

Test Plan (N=2, W=4 unless noted):
- Async reset asserted between edges -> all outputs 0 immediately, with no clock edge needed.
- req_i=01, en_i=01, data0=2 -> gnt_o=01 on cycle k+1, dout0=2 and done_o=01 on k+2, busy_o low on k+3.
- req_i=10, en_i=00, data1=7 -> full handshake completes, done_o=10 pulses, dout1 stays 0.
- req_i=11 held continuously, each requester dropping for one cycle on its done -> grants alternate 01,10,01,10. Second done occurs exactly 3 cycles after the first.
- Requester 0 holds req through its done_o cycle -> not re-granted next IDLE cycle; requester 1 (pending) wins.
- Reset pulse during SERVE with en=1, data=9 -> dout unchanged (0) after release, no done pulse.
- STATS_EN defined, N=3, 300 grants to req 2 -> grant_cnt_o[2]=44.

Source files
------------

// File: rtl/load_share_arbiter_pkg.sv
// Shared types for the load-share arbiter: FSM state encoding and the stats counter width.
package load_share_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SERVE = 2'd1,
    ACK   = 2'd2
  } state_t;

  localparam int STATS_W = 8;

endpackage

// File: rtl/load_share_arbiter_rr_pick.sv
// Combinational round-robin picker: first set bit of i_req_m scanning up from i_rr_ptr with wrap.
// Zero latency, no state.
module rr_pick #(
  parameter int N    = 2,
  parameter int IDXW = 1
) (
  input  logic [N-1:0]    i_req_m,
  input  logic [IDXW-1:0] i_rr_ptr,
  output logic            o_vld,
  output logic [IDXW-1:0] o_idx
);

  // Walk offsets from far to near so the nearest set bit overwrites earlier hits.
  always_comb begin
    int k;
    k     = 0;
    o_vld = 1'b0;
    o_idx = '0;
    for (int off = N - 1; off >= 0; off--) begin
      k = (int'(i_rr_ptr) + off) % N;
      if (i_req_m[k]) begin
        o_vld = 1'b1;
        o_idx = IDXW'(k);
      end
    end
  end

endmodule

// File: rtl/load_share_arbiter.sv
// Round-robin share of one conditional-load unit among N requesters; one load per 3-cycle IDLE->SERVE->ACK pass.
// Requesters hold req_i until done_o; LOAD_SHARE_ARBITER_STATS_EN adds per-requester grant counters.
module load_share_arbiter
  import load_share_pkg::*;
#(
  parameter int N = 2,
  parameter int W = 4
) (
  input  logic           clk,
  input  logic           rstn,
  input  logic [N-1:0]   req_i,
  input  logic [N-1:0]   en_i,
  input  logic [N*W-1:0] data_i,
  output logic [N-1:0]   gnt_o,
  output logic [N-1:0]   done_o,
  output logic [N*W-1:0] dout_o,
  output logic           busy_o
`ifdef LOAD_SHARE_ARBITER_STATS_EN
  ,
  output logic [N*STATS_W-1:0] grant_cnt_o
`endif
);

  localparam int IDXW = (N > 1) ? $clog2(N) : 1;

  state_t          r_state;
  logic [IDXW-1:0] r_g;
  logic [IDXW-1:0] r_rr_ptr;
  logic [N-1:0]    r_gnt;
  logic [N-1:0]    r_done;
  logic [N-1:0]    r_mask;
  logic            r_busy;
  logic [N*W-1:0]  r_dout;

  logic [N-1:0]    w_req_m;
  logic            w_vld;
  logic [IDXW-1:0] w_win;

`ifdef LOAD_SHARE_ARBITER_STATS_EN
  logic [N-1:0][STATS_W-1:0] r_cnt;
`endif

  function automatic logic [N-1:0] onehot(input logic [IDXW-1:0] idx);
    logic [N-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

  // r_mask is last cycle's done_o, so a requester that drops late is not re-granted straight away.
  assign w_req_m = req_i & ~r_mask;

  rr_pick #(
    .N    (N),
    .IDXW (IDXW)
  ) u_rr_pick (
    .i_req_m  (w_req_m),
    .i_rr_ptr (r_rr_ptr),
    .o_vld    (w_vld),
    .o_idx    (w_win)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state  <= IDLE;
      r_g      <= '0;
      r_rr_ptr <= '0;
      r_gnt    <= '0;
      r_done   <= '0;
      r_mask   <= '0;
      r_busy   <= 1'b0;
      r_dout   <= '0;
`ifdef LOAD_SHARE_ARBITER_STATS_EN
      r_cnt    <= '0;
`endif
    end else begin
      r_mask <= r_done;
      case (r_state)
        IDLE: begin
          if (w_vld) begin
            r_g     <= w_win;
            r_gnt   <= onehot(w_win);
            r_busy  <= 1'b1;
            r_state <= SERVE;
          end
        end
        SERVE: begin
          if (en_i[r_g]) begin
            r_dout[r_g*W +: W] <= data_i[r_g*W +: W];
          end
          r_gnt   <= '0;
          r_done  <= onehot(r_g);
          r_state <= ACK;
        end
        ACK: begin
          r_done   <= '0;
          r_busy   <= 1'b0;
          r_rr_ptr <= (r_g == IDXW'(N - 1)) ? '0 : r_g + 1'b1;
`ifdef LOAD_SHARE_ARBITER_STATS_EN
          r_cnt[r_g] <= r_cnt[r_g] + 1'b1;
`endif
          r_state  <= IDLE;
        end
        default: begin
          r_gnt   <= '0;
          r_done  <= '0;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign gnt_o  = r_gnt;
  assign done_o = r_done;
  assign busy_o = r_busy;
  assign dout_o = r_dout;

`ifdef LOAD_SHARE_ARBITER_STATS_EN
  assign grant_cnt_o = r_cnt;
`endif

endmodule

// File: tb/tb_load_share_arbiter.sv
// Randomized scoreboard bench for load_share_arbiter (N=2, W=4) against a transaction-level model.
module tb_load_share_arbiter;

  localparam int N = 2;
  localparam int W = 4;

  logic           clk = 1'b0;
  logic           rstn = 1'b0;
  logic [N-1:0]   req_i = '0;
  logic [N-1:0]   en_i = '0;
  logic [N*W-1:0] data_i = '0;
  logic [N-1:0]   gnt_o;
  logic [N-1:0]   done_o;
  logic [N*W-1:0] dout_o;
  logic           busy_o;
`ifdef LOAD_SHARE_ARBITER_STATS_EN
  logic [N*8-1:0] grant_cnt_o;
`endif

  load_share_arbiter #(.N(N), .W(W)) dut (
    .clk    (clk),
    .rstn   (rstn),
    .req_i  (req_i),
    .en_i   (en_i),
    .data_i (data_i),
    .gnt_o  (gnt_o),
    .done_o (done_o),
    .dout_o (dout_o),
    .busy_o (busy_o)
`ifdef LOAD_SHARE_ARBITER_STATS_EN
    ,
    .grant_cnt_o (grant_cnt_o)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int             cyc;
    int             g;
    logic [N-1:0]   vec;
    logic [N*W-1:0] dout;
  } exp_t;

  exp_t gq[$];
  exp_t dq[$];

  int checks = 0;
  int errors = 0;
  int ecnt = 0;
  int free_edge = 0;
  int mask_edge = -1;
  int mask_g = 0;
  int last_k = -100;
  int ptr_m = 0;
  int dout_m[N];
  int cnt_m[N];
  bit rand_on = 1'b0;
  bit reqd[N];
  bit late[N];
  int drop_cnt[N];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, ecnt, act, expv);
    end
  endtask

  function automatic logic [N*W-1:0] dout_vec();
    logic [N*W-1:0] v;
    v = '0;
    for (int i = 0; i < N; i++) v[i*W +: W] = W'(dout_m[i]);
    return v;
  endfunction

  // Reference model: at each edge, if the unit is free, pick the first requester at or after the
  // pointer (skipping the one just served), then predict grant, completion and dout contents.
  always @(posedge clk) begin
    logic [N-1:0] m;
    int found;
    int k;
    exp_t e;
    ecnt++;
    if (!rstn) begin
      free_edge = 0;
      mask_edge = -1;
      last_k    = -100;
      ptr_m     = 0;
      for (int i = 0; i < N; i++) begin
        dout_m[i] = 0;
        cnt_m[i]  = 0;
      end
      gq.delete();
      dq.delete();
    end else if (ecnt >= free_edge) begin
      m = req_i;
      if (ecnt == mask_edge) m[mask_g] = 1'b0;
      found = -1;
      for (int off = 0; off < N; off++) begin
        k = (ptr_m + off) % N;
        if (found < 0 && m[k]) found = k;
      end
      if (found >= 0) begin
        e.cyc  = ecnt;
        e.g    = found;
        e.vec  = '0;
        e.vec[found] = 1'b1;
        e.dout = '0;
        gq.push_back(e);
        if (en_i[found]) dout_m[found] = int'(data_i[found*W +: W]);
        e.cyc  = ecnt + 1;
        e.dout = dout_vec();
        dq.push_back(e);
        ptr_m     = (found + 1) % N;
        free_edge = ecnt + 3;
        mask_edge = ecnt + 3;
        mask_g    = found;
        last_k    = ecnt;
      end
    end
  end

  // Monitor: compares whatever the DUT presents against the front of the expectation queues.
  always @(negedge clk) begin
    logic [N-1:0] eg;
    logic [N-1:0] ed;
    if (rstn) begin
      eg = (gq.size() > 0 && gq[0].cyc == ecnt) ? gq[0].vec : '0;
      if (gnt_o != '0 || eg != '0) chk("gnt", 64'(gnt_o), 64'(eg));
      if (eg != '0) void'(gq.pop_front());
      ed = (dq.size() > 0 && dq[0].cyc == ecnt) ? dq[0].vec : '0;
      if (done_o != '0 || ed != '0) chk("done", 64'(done_o), 64'(ed));
      if (ed != '0) begin
        chk("dout", 64'(dout_o), 64'(dq[0].dout));
        cnt_m[dq[0].g]++;
        void'(dq.pop_front());
      end
      chk("busy", 64'(busy_o), 64'(ecnt == last_k || ecnt == last_k + 1));
    end
  end

  task automatic raise(input int i, input bit en, input int d, input bit lt);
    req_i[i]          = 1'b1;
    en_i[i]           = en;
    data_i[i*W +: W]  = W'(d);
    reqd[i]           = 1'b1;
    late[i]           = lt;
    drop_cnt[i]       = 0;
  endtask

  // One cycle of requester behaviour: drop on done (or two cycles later when late), maybe re-request.
  task automatic step();
    @(negedge clk);
    for (int i = 0; i < N; i++) begin
      if (reqd[i]) begin
        if (drop_cnt[i] > 0) begin
          drop_cnt[i]--;
          if (drop_cnt[i] == 0) begin
            req_i[i] = 1'b0;
            reqd[i]  = 1'b0;
          end
        end else if (done_o[i]) begin
          if (late[i]) drop_cnt[i] = 2;
          else begin
            req_i[i] = 1'b0;
            reqd[i]  = 1'b0;
          end
        end
      end else if (rand_on) begin
        if ($urandom_range(3) == 0)
          raise(i, 1'($urandom_range(1)), int'($urandom_range(15)), $urandom_range(2) == 0);
        else begin
          en_i[i]          = 1'($urandom_range(1));
          data_i[i*W +: W] = W'($urandom_range(15));
        end
      end
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_gnt"}, 64'(gnt_o), 64'(0));
    chk({tag, "_done"}, 64'(done_o), 64'(0));
    chk({tag, "_busy"}, 64'(busy_o), 64'(0));
    chk({tag, "_dout"}, 64'(dout_o), 64'(0));
  endtask

  initial begin
    int n;
    for (int i = 0; i < N; i++) begin
      reqd[i]     = 1'b0;
      late[i]     = 1'b0;
      drop_cnt[i] = 0;
    end
    repeat (3) @(posedge clk);
    #2;
    chk_reset_outputs("por");
    @(negedge clk);
    rstn = 1'b1;

    raise(0, 1'b1, 2, 1'b0);
    repeat (6) step();
    raise(1, 1'b0, 7, 1'b0);
    repeat (6) step();
    raise(0, 1'b1, 5, 1'b0);
    raise(1, 1'b1, 3, 1'b0);
    repeat (10) step();
    raise(0, 1'b1, 4, 1'b1);
    repeat (3) step();
    raise(1, 1'b1, 6, 1'b0);
    repeat (12) step();

    // Reset between edges while requester 0 is in SERVE with a pending enabled load.
    raise(0, 1'b1, 9, 1'b0);
    n = 0;
    while (gnt_o[0] !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    chk("serve_reached", 64'(n < 20), 64'(1));
    #2;
    rstn = 1'b0;
    #1;
    chk_reset_outputs("async");
    req_i = '0;
    for (int i = 0; i < N; i++) begin
      reqd[i]     = 1'b0;
      drop_cnt[i] = 0;
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rstn = 1'b1;
    repeat (6) step();
    chk("post_reset_dout", 64'(dout_o), 64'(0));

    rand_on = 1'b1;
    repeat (3000) step();
    rand_on = 1'b0;
    repeat (30) step();

    chk("queues_drained", 64'(gq.size() + dq.size()), 64'(0));
    chk("final_dout", 64'(dout_o), 64'(dout_vec()));
`ifdef LOAD_SHARE_ARBITER_STATS_EN
    for (int i = 0; i < N; i++)
      chk("grant_cnt", 64'(grant_cnt_o[i*8 +: 8]), 64'(cnt_m[i] % 256));
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
